// File: rtl/my_pc_ctrl.sv
// Hack PC sequencer: BOOT -> FETCH (waits on instr_ready) -> EXEC -> UPDATE, 3 cycles/instr with ROM ready.
// Optional HALT_DETECT_EN macro: a jump-to-self in UPDATE parks the FSM in HALTED until reset.
module my_pc_ctrl #(
   parameter int WIDTH       = 16,
   parameter int BOOT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc_out,
   input  logic [WIDTH-1:0] a_reg,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_ready,
   input  logic             zr,
   input  logic             ng,
   output logic             fetch_req,
   output logic [WIDTH-1:0] ir,
   output logic             exec_en,
   output logic             pc_reset,
   output logic             pc_load,
   output logic             pc_inc,
   output logic             halted
);

   localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      UPDATE = 3'd3,
      HALTED = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] boot_cnt;
   logic             jump;
   logic             self_loop;

   // Hack jump bits: j2 = out<0, j1 = out==0, j0 = out>0; A-instructions never jump
   assign jump = ir[WIDTH-1] & ((ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr));

`ifdef HALT_DETECT_EN
   assign self_loop = jump & (a_reg == pc_out);
`else
   logic unused_ok;
   assign self_loop = 1'b0;
   assign unused_ok = ^{a_reg, pc_out};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         boot_cnt <= '0;
         ir       <= '0;
      end else begin
         if (state == BOOT) begin
            boot_cnt <= boot_cnt + CNT_W'(1);
         end
         if (state == FETCH && instr_ready) begin
            ir <= instr;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    if (boot_cnt == BOOT_LAST) state_nxt = FETCH;
         FETCH:   if (instr_ready) state_nxt = EXEC;
         EXEC:    state_nxt = UPDATE;
         UPDATE:  state_nxt = self_loop ? HALTED : FETCH;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      pc_reset  = (state == BOOT);
      fetch_req = (state == FETCH);
      exec_en   = (state == EXEC);
      pc_load   = (state == UPDATE) &  jump;
      pc_inc    = (state == UPDATE) & ~jump;
`ifdef HALT_DETECT_EN
      halted    = (state == HALTED);
`else
      halted    = 1'b0;
`endif
   end

endmodule
